// File: rtl/blockmem_pkg.sv
// blockmem_pkg
//   Shared constants for the block memory reader: default address/data
//   widths of the 256 x 32 operand memory and the reader FSM state encoding.
package blockmem_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/blockmem_reader_fifo.sv
// blockmem_reader_fifo
//   Two-entry output FIFO for the block memory reader. Each entry holds a
//   data word plus its last flag. The head entry drives the outputs
//   directly from registers; the second entry only fills while the sink is
//   stalled.
// Ports:
//   clk, reset     system clock, asynchronous active-high reset
//   wr_en_i        write one entry this cycle
//   wr_data_i      word to write
//   wr_last_i      last flag to write
//   rd_en_i        pop the head entry (only meaningful while rd_valid_o)
//   rd_valid_o     head entry valid
//   rd_data_o      head word
//   rd_last_o      head last flag
//   count_o        number of occupied entries (0..2)
module blockmem_reader_fifo
  import blockmem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  wr_last_i,
  input  logic                  rd_en_i,
  output logic                  rd_valid_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_last_o,
  output logic [1:0]            count_o
);

  logic [DATA_WIDTH:0] head_q, head_d;
  logic [DATA_WIDTH:0] tail_q, tail_d;
  logic [1:0]          count_q, count_d;
  logic [DATA_WIDTH:0] wr_entry;
  logic                pop;

  assign wr_entry = {wr_last_i, wr_data_i};
  assign pop      = rd_en_i && (count_q != 2'd0);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({wr_en_i, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = wr_entry;
        else                 tail_d = wr_entry;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        // Head keeps its stale value when the FIFO empties.
        if (count_q == 2'd2) head_d = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd2) begin
          head_d = tail_q;
          tail_d = wr_entry;
        end else begin
          head_d = wr_entry;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign rd_valid_o = (count_q != 2'd0);
  assign rd_data_o  = head_q[DATA_WIDTH-1:0];
  assign rd_last_o  = head_q[DATA_WIDTH];
  assign count_o    = count_q;

endmodule

// File: rtl/blockmem_reader.sv
// blockmem_reader
//   Read-side initiator for a synchronous block memory with one-cycle
//   registered read. A start command issues a run of consecutive read
//   addresses from base_addr and streams the returned words out on a
//   valid/ready interface with full backpressure, one word per cycle while
//   the sink is ready.
// Ports:
//   clk, reset       system clock, asynchronous active-high reset
//   start            begin a transfer (sampled only in IDLE)
//   base_addr        first word address, sampled with start
//   length           word count 0..2^ADDR_WIDTH, sampled with start
//   reverse          (BLOCKMEM_READER_REVERSE_EN only) descending order
//   busy             high whenever not IDLE
//   done             one-cycle pulse after a transfer completes
//   mem_read_addr    memory read address
//   mem_read_data    memory read data, valid the cycle after its address
//   out_valid/out_ready/out_data/out_last   output stream
// Configuration:
//   BLOCKMEM_READER_REVERSE_EN adds the reverse input; reverse=1 reads from
//   base_addr+length-1 down to base_addr.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; length 0 only pulses done
// RUN   | issuing reads while the FIFO has room
// DRAIN | all reads issued, waiting for the last word to be accepted
module blockmem_reader
  import blockmem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
`ifdef BLOCKMEM_READER_REVERSE_EN
  input  logic                  reverse,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
  logic [ADDR_WIDTH:0]   issue_cnt_q, issue_cnt_d;
  logic [ADDR_WIDTH:0]   out_cnt_q, out_cnt_d;
  logic                  in_flight_q, in_flight_d;
  logic                  done_q, done_d;

  logic                  rev_in;
  logic                  dir_down;
  logic [ADDR_WIDTH-1:0] first_addr;
  logic                  issue;
  logic                  pop;
  logic [2:0]            occ;
  logic [1:0]            fifo_count;
  logic                  fifo_last;
  logic                  wr_last;

`ifdef BLOCKMEM_READER_REVERSE_EN
  logic rev_q, rev_d;

  assign rev_in   = reverse;
  assign dir_down = rev_q;
  assign rev_d    = (state_q == ST_IDLE && start) ? reverse : rev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rev_q <= 1'b0;
    else       rev_q <= rev_d;
  end
`else
  assign rev_in   = 1'b0;
  assign dir_down = 1'b0;
`endif

  // Descending runs start at the top word; length 2^ADDR_WIDTH wraps to base-1.
  assign first_addr = rev_in ? (base_addr + length[ADDR_WIDTH-1:0] - ADDR_ONE)
                             : base_addr;

  assign pop = out_valid && out_ready;
  // Slots already committed after this cycle: stored words plus the word on
  // the memory bus, less the one leaving. Keeping this below 2 means every
  // issued read has a FIFO slot when its data arrives.
  assign occ   = {1'b0, fifo_count} + {2'b00, in_flight_q} - {2'b00, pop};
  assign issue = (state_q == ST_RUN) && (issue_cnt_q != '0) && (occ < 3'd2);

  assign wr_last = (out_cnt_q == CNT_ONE);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    hold_addr_d = hold_addr_q;
    issue_cnt_d = issue_cnt_q;
    out_cnt_d   = out_cnt_q;
    in_flight_d = issue;
    done_d      = 1'b0;

    if (in_flight_q) out_cnt_d = out_cnt_q - CNT_ONE;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d      = first_addr;
            issue_cnt_d = length;
            out_cnt_d   = length;
            state_d     = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (issue) begin
          hold_addr_d = addr_q;
          addr_d      = dir_down ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
          issue_cnt_d = issue_cnt_q - CNT_ONE;
          if (issue_cnt_q == CNT_ONE) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && fifo_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      hold_addr_q <= '0;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      in_flight_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      hold_addr_q <= hold_addr_d;
      issue_cnt_q <= issue_cnt_d;
      out_cnt_q   <= out_cnt_d;
      in_flight_q <= in_flight_d;
      done_q      <= done_d;
    end
  end

  blockmem_reader_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .wr_en_i    (in_flight_q),
    .wr_data_i  (mem_read_data),
    .wr_last_i  (wr_last),
    .rd_en_i    (pop),
    .rd_valid_o (out_valid),
    .rd_data_o  (out_data),
    .rd_last_o  (fifo_last),
    .count_o    (fifo_count)
  );

  // The address port shows the live counter while issuing and otherwise
  // holds the last address actually issued.
  assign mem_read_addr = issue ? addr_q : hold_addr_q;
  assign out_last      = fifo_last;
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;

endmodule

// File: tb/tb_blockmem_reader.sv
module tb_blockmem_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_addr = 8'h00;
  logic [8:0]  length = 9'd0;
`ifdef BLOCKMEM_READER_REVERSE_EN
  logic        reverse = 1'b0;
`endif
  logic        busy;
  logic        done;
  logic [7:0]  mem_read_addr;
  logic [31:0] mem_read_data = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_last;

  blockmem_reader u_dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .length        (length),
`ifdef BLOCKMEM_READER_REVERSE_EN
    .reverse       (reverse),
`endif
    .busy          (busy),
    .done          (done),
    .mem_read_addr (mem_read_addr),
    .mem_read_data (mem_read_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last)
  );

  always #5 clk = ~clk;

  // Memory word at address a is 0xBEEF00aa.
  logic [31:0] mem [256];
  always @(posedge clk) mem_read_data <= mem[mem_read_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitor, sampled on the falling edge.
  logic [31:0] got_data[$];
  logic        got_last[$];
  int          first_valid_cyc = -1;
  int          last_hs_cyc = -1;
  int          done_cyc = -1;
  int          done_cnt = 0;
  bit          busy_seen = 0;
  bit          stall_pend = 0;
  logic [31:0] stall_data = 0;
  logic        stall_last = 0;
  int          max_fifo = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (stall_pend) begin
        check("stall_valid", {63'd0, out_valid}, 64'd1);
        check("stall_data", {32'd0, out_data}, {32'd0, stall_data});
        check("stall_last", {63'd0, out_last}, {63'd0, stall_last});
      end
      stall_pend = out_valid && !out_ready;
      stall_data = out_data;
      stall_last = out_last;
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
        last_hs_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_seen = 1;
      if (int'(u_dut.u_fifo.count_o) > max_fifo) max_fifo = int'(u_dut.u_fifo.count_o);
    end
  end

  task automatic clear_mon();
    got_data.delete();
    got_last.delete();
    first_valid_cyc = -1;
    last_hs_cyc = -1;
    done_cyc = -1;
    done_cnt = 0;
    busy_seen = 0;
    stall_pend = 0;
    max_fifo = 0;
  endtask

  // mode 0: out_ready held high; mode 1: out_ready 1,0,0,1 repeating and a
  // second start pulse while busy.
  task automatic run_xfer(input string name, input logic [7:0] base, input logic [8:0] len,
                          input logic rev, input int mode);
    int          start_cyc;
    int          n;
    logic [7:0]  a;
    logic [7:0]  top;
    clear_mon();
    start     = 1'b1;
    base_addr = base;
    length    = len;
`ifdef BLOCKMEM_READER_REVERSE_EN
    reverse   = rev;
`endif
    out_ready = 1'b1;
    start_cyc = cyc;
    tick();
    start     = 1'b0;
    base_addr = 8'($urandom);
    length    = 9'($urandom);
`ifdef BLOCKMEM_READER_REVERSE_EN
    reverse   = ~rev;
`endif
    for (n = 0; n < 200 && done_cnt == 0; n++) begin
      if (mode == 1) begin
        case ((cyc - start_cyc) % 4)
          1, 2:    out_ready = 1'b0;
          default: out_ready = 1'b1;
        endcase
        start     = (n == 3);
        base_addr = 8'h77;
        length    = 9'd5;
      end
      tick();
    end
    start     = 1'b0;
    out_ready = 1'b1;
    check({name, "_timeout"}, {63'd0, done_cnt != 0}, 64'd1);
    tick();
    tick();
    check({name, "_done_once"}, 64'(done_cnt), 64'd1);
    check({name, "_count"}, 64'(got_data.size()), {55'd0, len});
    top = base + len[7:0] - 8'd1;
    for (int k = 0; k < got_data.size() && k < int'(len); k++) begin
      a = rev ? (top - 8'(k)) : (base + 8'(k));
      check($sformatf("%s_data%0d", name, k), {32'd0, got_data[k]}, {32'd0, 16'hBEEF, 8'h00, a});
      check($sformatf("%s_last%0d", name, k), {63'd0, got_last[k]}, {63'd0, k == int'(len) - 1});
    end
    if (len == 9'd0) begin
      check({name, "_done_cyc"}, 64'(done_cyc), 64'(start_cyc + 1));
      check({name, "_busy"}, {63'd0, busy_seen}, 64'd0);
      check({name, "_no_valid"}, 64'(first_valid_cyc), 64'(-1));
    end else begin
      check({name, "_done_cyc"}, 64'(done_cyc), 64'(last_hs_cyc + 1));
      check({name, "_fifo_max"}, {63'd0, max_fifo <= 2}, 64'd1);
      if (mode == 0) begin
        check({name, "_first_valid"}, 64'(first_valid_cyc), 64'(start_cyc + 3));
        check({name, "_back2back"}, 64'(last_hs_cyc - first_valid_cyc), 64'(int'(len) - 1));
      end
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = {16'hBEEF, 8'h00, 8'(i)};

    reset = 1'b1;
    tick();
    tick();
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_last", {63'd0, out_last}, 64'd0);
    check("rst_data", {32'd0, out_data}, 64'd0);
    check("rst_addr", {56'd0, mem_read_addr}, 64'd0);
    reset = 1'b0;
    tick();

    run_xfer("basic", 8'h10, 9'd4, 1'b0, 0);
    run_xfer("wrap", 8'hFE, 9'd4, 1'b0, 0);
    run_xfer("len0", 8'h33, 9'd0, 1'b0, 0);
    run_xfer("len1", 8'hFF, 9'd1, 1'b0, 0);
    run_xfer("stall", 8'h80, 9'd8, 1'b0, 1);

    // Reset in the middle of an 8-word transfer after 3 words accepted.
    clear_mon();
    start     = 1'b1;
    base_addr = 8'h40;
    length    = 9'd8;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (n = 0; n < 50 && got_data.size() < 3; n++) tick();
    check("rst_mid_wait", 64'(got_data.size()), 64'd3);
    reset = 1'b1;
    #1;
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    check("rst_mid_done", {63'd0, done}, 64'd0);
    check("rst_mid_valid", {63'd0, out_valid}, 64'd0);
    check("rst_mid_last", {63'd0, out_last}, 64'd0);
    check("rst_mid_data", {32'd0, out_data}, 64'd0);
    check("rst_mid_addr", {56'd0, mem_read_addr}, 64'd0);
    tick();
    reset = 1'b0;
    tick();
    run_xfer("after_rst", 8'h00, 9'd2, 1'b0, 0);

`ifdef BLOCKMEM_READER_REVERSE_EN
    run_xfer("rev", 8'h20, 9'd3, 1'b1, 0);
    run_xfer("fwd", 8'h20, 9'd3, 1'b0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
